pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Detects load-use hazards between ID and EX, freezes the pipe while the data memory is busy, and squashes wrong-path instructions after an EX-stage redirect.
- Drives the hold/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It is the single owner of every stall decision; the pipeline registers only obey.

Parameters:
- FLUSH_EXTRA, 1, extra flush cycles after the redirect cycle, covering fetch latency; 0..7.
- MEM_TIMEOUT, 64, consecutive MEMWAIT cycles before mem_timeout is raised; range 2..255.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- id_rs1addr  in  5  ID source register 1
- id_rs2addr  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rdaddr  in  5  EX destination register
- ex_regwr  in  1  EX writes the register file
- ex_isload  in  1  EX instruction is a load
- ex_redirect  in  1  taken branch or jump resolved in EX
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory completes this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_stall  out  1  hold ID/EX
- idex_bubble  out  1  load NOP into ID/EX (regwr=0, memwr=0)
- exmem_stall  out  1  hold EX/MEM
- ctrl_state  out  2  current FSM state
- mem_timeout  out  1  sticky; memory wait exceeded MEM_TIMEOUT
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating

Behaviour:
- Definitions (combinational):
  - lu_haz = ex_isload & ex_regwr & (ex_rdaddr!=0) & ((id_use_rs1 & id_rs1addr==ex_rdaddr) | (id_use_rs2 & id_rs2addr==ex_rdaddr)).
  - mw = mem_req & !mem_ready.
- Outputs are combinational from the registered state and the current inputs. Zero added latency: controls act in the same cycle as the condition.
- Conflict rule: where the flush and stall controls of IF/ID or ID/EX are both asserted, flush/bubble wins at that register.
- Reset (rst=0, async):
  - state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0, stall_cnt=0.
  - While reset is held: pc_stall=1, ifid_flush=1, idex_bubble=1; all other controls 0.
- States: RUN=0, LDUSE=1, MEMWAIT=2, FLUSH=3.
- RUN, priority mw > ex_redirect > lu_haz:
  - mw: assert pc_stall, ifid_stall, idex_stall, exmem_stall; go to MEMWAIT.
  - ex_redirect: assert ifid_flush, idex_bubble. If FLUSH_EXTRA>0, go to FLUSH with flush_cnt=FLUSH_EXTRA; otherwise stay in RUN.
  - lu_haz: assert pc_stall, ifid_stall, idex_bubble; go to LDUSE.
  - None of the above: all controls 0.
- LDUSE: behaves as RUN, except lu_haz is ignored, so there is exactly one bubble per load-use pair. Next state is RUN unless mw or ex_redirect selects otherwise.
- MEMWAIT:
  - While mw: assert all four stall controls; wait_cnt increments.
  - When wait_cnt reaches MEM_TIMEOUT-1, mem_timeout is set and held until reset; the wait continues.
  - On the mem_ready cycle: wait_cnt=0; the stall outputs drop and the RUN priority rules are evaluated with mw=0, so a held ex_redirect is acted on in that cycle.
- FLUSH:
  - Each cycle: assert ifid_flush, idex_bubble; flush_cnt decrements; at 1 the next state is RUN.
  - A new ex_redirect reloads flush_cnt=FLUSH_EXTRA.
  - If mw: also assert all four stall controls and freeze flush_cnt.
- stall_cnt increments on every post-reset cycle with pc_stall=1 and saturates at 2^CNT_W-1.
- ex_rdaddr=0 never produces a hazard.

Test Plan:
- Load-use: EX lw x5 (ex_isload=1, ex_regwr=1, rd=5); ID add reads rs1=5 -> one cycle of pc_stall=1, ifid_stall=1, idex_bubble=1; next cycle all 0; ctrl_state 0->1->0; stall_cnt=1.
- No false hazard: load with rd=0 and ID rs1=0 -> no stall. Non-load ex_regwr=1 with rd=5 matching ID rs1=5 -> no stall.
- Redirect: ex_redirect pulse with FLUSH_EXTRA=1 -> ifid_flush=1 and idex_bubble=1 for 2 cycles; state 0->3->0. With FLUSH_EXTRA=0 -> flush for 1 cycle only, state stays 0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all four stall controls=1 for 3 cycles, 0 on the ready cycle; stall_cnt=3.
- Simultaneous events:
  - mw + ex_redirect + lu_haz in RUN -> MEMWAIT only.
  - On the ready cycle with ex_redirect still 1 -> flush asserted that cycle.
  - mw during FLUSH -> flush_cnt frozen; flush and stall controls both 1.
- Timeout and reset: MEM_TIMEOUT=4, mem_ready held low -> mem_timeout=1 after the 4th wait cycle, staying 1 after ready. rst=0 mid-MEMWAIT -> immediate state=0, mem_timeout=0, stall_cnt=0, pc_stall=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32 pipeline. It detects
//   load-use hazards between ID and EX, freezes the pipe while data memory is
//   busy, and squashes wrong-path instructions after an EX-stage redirect.
//   Every control output is combinational from the registered state and the
//   current inputs, so a control acts in the same cycle as its condition.
//   Where a flush/bubble and a stall of the same register are both asserted,
//   the pipeline register gives the flush/bubble priority.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   id_rs1addr, id_rs2addr    ID source registers
//   id_use_rs1, id_use_rs2    ID instruction reads rs1 / rs2
//   ex_rdaddr, ex_regwr       EX destination register / writes register file
//   ex_isload                 EX instruction is a load
//   ex_redirect               taken branch or jump resolved in EX
//   mem_req, mem_ready        MEM stage access pending / completes this cycle
//   pc_stall                  hold PC
//   ifid_stall, ifid_flush    hold IF/ID, load NOP into IF/ID
//   idex_stall, idex_bubble   hold ID/EX, load NOP into ID/EX
//   exmem_stall               hold EX/MEM
//   ctrl_state                current state (RUN=0, LDUSE=1, MEMWAIT=2, FLUSH=3)
//   mem_timeout               sticky: memory wait reached MEM_TIMEOUT cycles
//   stall_cnt                 saturating count of cycles with pc_stall=1
module pipe_hazard_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1addr,
    input  logic [4:0]       id_rs2addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rdaddr,
    input  logic             ex_regwr,
    input  logic             ex_isload,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_bubble,
    output logic             exmem_stall,
    output logic [1:0]       ctrl_state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [2:0] flush_cnt, flush_nx;
    logic [7:0] wait_cnt;
    logic       lu_haz;
    logic       mw;

    assign lu_haz = ex_isload && ex_regwr && (ex_rdaddr != 5'd0) &&
                    ((id_use_rs1 && (id_rs1addr == ex_rdaddr)) ||
                     (id_use_rs2 && (id_rs2addr == ex_rdaddr)));
    assign mw     = mem_req && !mem_ready;

    assign ctrl_state = state;

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_bubble = 1'b0;
        exmem_stall = 1'b0;
        state_nx    = state;
        flush_nx    = flush_cnt;

        case (state)
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (mw) begin
                    // Memory busy: keep squashing but freeze the countdown.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else if (ex_redirect) begin
                    flush_nx = 3'(FLUSH_EXTRA);
                end else begin
                    flush_nx = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state_nx = RUN;
                    end
                end
            end
            default: begin
                // RUN, LDUSE and the ready cycle of MEMWAIT share the RUN
                // priority; in MEMWAIT mw=0 here exactly on the ready cycle.
                // LDUSE ignores lu_haz so each load-use pair costs one bubble.
                if (mw) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    state_nx    = MEMWAIT;
                end else if (ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_EXTRA > 0) begin
                        state_nx = FLUSH;
                        flush_nx = 3'(FLUSH_EXTRA);
                    end else begin
                        state_nx = RUN;
                    end
                end else if (lu_haz && (state != LDUSE)) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    state_nx    = LDUSE;
                end else begin
                    state_nx = RUN;
                end
            end
        endcase

        // Held reset keeps the front of the pipe frozen and filled with NOPs.
        if (!rst) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b1;
            idex_stall  = 1'b0;
            idex_bubble = 1'b1;
            exmem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_nx;

            // wait_cnt counts MEMWAIT cycles after the entry cycle, so the
            // flag rises after MEM_TIMEOUT consecutive wait cycles in total.
            if ((state == MEMWAIT) && mw) begin
                if (wait_cnt != 8'(MEM_TIMEOUT - 1)) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (wait_cnt == 8'(MEM_TIMEOUT - 2)) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies inputs on the
// falling edge and pushes the reference model's expected outputs; a monitor
// samples the DUT shortly after and compares against the popped entry.
module tb_pipe_hazard_ctrl;

    localparam int FE    = 1;
    localparam int MT    = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             pc_stall;
        logic             ifid_stall;
        logic             ifid_flush;
        logic             idex_stall;
        logic             idex_bubble;
        logic             exmem_stall;
        logic [1:0]       state;
        logic             timeout;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1addr, id_rs2addr, ex_rdaddr;
    logic             id_use_rs1, id_use_rs2, ex_regwr, ex_isload;
    logic             ex_redirect, mem_req, mem_ready;
    logic             pc_stall, ifid_stall, ifid_flush, idex_stall;
    logic             idex_bubble, exmem_stall, mem_timeout;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    exp_t exp_q[$];

    // Reference model state, in terms of pending work rather than FSM states.
    int flush_left;   // flush cycles still owed after the current one
    bit waiting;      // previous cycle stalled on memory outside a flush
    bit after_ld;     // previous cycle inserted a load-use bubble
    int wait_run;     // consecutive memory-wait cycles outside a flush
    bit to_flag;
    int scnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_EXTRA(FE),
        .MEM_TIMEOUT(MT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rs1addr (id_rs1addr),
        .id_rs2addr (id_rs2addr),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rdaddr  (ex_rdaddr),
        .ex_regwr   (ex_regwr),
        .ex_isload  (ex_isload),
        .ex_redirect(ex_redirect),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .pc_stall   (pc_stall),
        .ifid_stall (ifid_stall),
        .ifid_flush (ifid_flush),
        .idex_stall (idex_stall),
        .idex_bubble(idex_bubble),
        .exmem_stall(exmem_stall),
        .ctrl_state (ctrl_state),
        .mem_timeout(mem_timeout),
        .stall_cnt  (stall_cnt)
    );

    task automatic model_clear();
        flush_left = 0;
        waiting    = 0;
        after_ld   = 0;
        wait_run   = 0;
        to_flag    = 0;
        scnt       = 0;
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        e = '0;
        e.pc_stall    = 1'b1;
        e.ifid_flush  = 1'b1;
        e.idex_bubble = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic rdr, input logic req, input logic rdy);
        exp_t e;
        bit haz, mw;
        int nfl;
        bit nwait, nld;
        @(negedge clk);
        rst = 1'b1;
        id_rs1addr = rs1; id_rs2addr = rs2;
        id_use_rs1 = u1;  id_use_rs2 = u2;
        ex_rdaddr  = rd;  ex_regwr   = rw; ex_isload = ld;
        ex_redirect = rdr; mem_req = req; mem_ready = rdy;

        haz = ld && rw && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        mw  = req && !rdy;
        e = '0;
        nfl = 0; nwait = 0; nld = 0;
        if (flush_left > 0) begin
            e.state = 2'd3;
            e.ifid_flush = 1'b1; e.idex_bubble = 1'b1;
            if (mw) begin
                e.pc_stall = 1; e.ifid_stall = 1; e.idex_stall = 1; e.exmem_stall = 1;
                nfl = flush_left;
            end else if (rdr) begin
                nfl = FE;
            end else begin
                nfl = flush_left - 1;
            end
        end else begin
            e.state = waiting ? 2'd2 : (after_ld ? 2'd1 : 2'd0);
            if (mw) begin
                e.pc_stall = 1; e.ifid_stall = 1; e.idex_stall = 1; e.exmem_stall = 1;
                nwait = 1;
            end else if (rdr) begin
                e.ifid_flush = 1; e.idex_bubble = 1;
                nfl = FE;
            end else if (haz && !after_ld) begin
                e.pc_stall = 1; e.ifid_stall = 1; e.idex_bubble = 1;
                nld = 1;
            end
        end
        e.timeout = to_flag;
        e.cnt     = CNT_W'(scnt);
        exp_q.push_back(e);

        if (mw && flush_left == 0) wait_run++;
        else wait_run = 0;
        if (wait_run >= MT) to_flag = 1;
        if (e.pc_stall && scnt < CMAX) scnt++;
        flush_left = nfl;
        waiting    = nwait;
        after_ld   = nld;
    endtask

    task automatic idle();
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc_no);
        end
    endtask

    // Monitor: samples outputs 2 time units after inputs change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_stall",    int'(pc_stall),    int'(e.pc_stall));
                chk("ifid_stall",  int'(ifid_stall),  int'(e.ifid_stall));
                chk("ifid_flush",  int'(ifid_flush),  int'(e.ifid_flush));
                chk("idex_stall",  int'(idex_stall),  int'(e.idex_stall));
                chk("idex_bubble", int'(idex_bubble), int'(e.idex_bubble));
                chk("exmem_stall", int'(exmem_stall), int'(e.exmem_stall));
                chk("ctrl_state",  int'(ctrl_state),  int'(e.state));
                chk("mem_timeout", int'(mem_timeout), int'(e.timeout));
                chk("stall_cnt",   int'(stall_cnt),   int'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        id_rs1addr = '0; id_rs2addr = '0; ex_rdaddr = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_regwr = 0; ex_isload = 0;
        ex_redirect = 0; mem_req = 0; mem_ready = 0;
        model_clear();

        do_reset();
        // Load-use: lw x5 in EX, add reading x5 in ID, then held once more.
        cyc(5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 0, 0, 0);
        cyc(5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 0, 0, 0);
        idle();
        // No false hazards: rd=0 load, non-load writer, unused operand.
        cyc(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0);
        cyc(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0);
        cyc(5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, 0, 0);
        // Redirect pulse.
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        idle(); idle();
        // Memory wait 3 cycles then ready.
        repeat (3) cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        idle();
        // mw + redirect + hazard together, redirect held through ready.
        cyc(5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 1, 1, 0);
        cyc(5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 1, 1, 0);
        cyc(5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 1, 1, 1);
        idle(); idle();
        // Memory wait during a flush.
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        repeat (2) cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        idle(); idle();
        // Timeout, sticky after ready, then reset in the middle of a wait.
        repeat (6) cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        idle();
        repeat (2) cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        do_reset();
        idle();

        // Randomized traffic with occasional resets and long memory waits.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a1, a2, rd;
            bit slow;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                a1 = 5'($urandom_range(0, 3));
                a2 = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                slow = ((i / 200) % 2) == 1;
                cyc(a1, a2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 2) == 0),
                    slow ? 1'($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
